// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that packs little-endian words into instruction memory
// Holds the core in reset (BUSY) while a program is streamed in and written word by word.
module imem_loader #(
  parameter int DEPTH     = 501,
  parameter int BASE_ADDR = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 START,
  input  logic [CNT_WIDTH-1:0] WORD_COUNT,
  input  logic [7:0]           BYTE_IN,
  input  logic                 BYTE_VALID,
  output logic                 BYTE_READY,
  output logic                 MEM_WE,
  output logic [63:0]          MEM_ADDR,
  output logic [31:0]          MEM_DATA,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 ERROR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECV   = 2'd1,
    S_WRITE  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [63:0]          addr_q, addr_d;
  logic [23:0]          asm_q, asm_d;
  logic [31:0]          data_q, data_d;
  logic [1:0]           idx_q, idx_d;
  logic                 err_q, err_d;
  logic [32:0]          end_idx;
  logic                 overflow;

  // Rejecting oversize loads up front is what keeps every write index below DEPTH.
  assign end_idx  = 33'(BASE_ADDR) + 33'(WORD_COUNT);
  assign overflow = end_idx > 33'(DEPTH);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= 64'(BASE_ADDR);
      asm_q   <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (START && !overflow) begin
          state_d = (WORD_COUNT == '0) ? S_FINISH : S_RECV;
        end
      end
      S_RECV: begin
        if (BYTE_VALID && idx_q == 2'd3) state_d = S_WRITE;
      end
      S_WRITE: begin
        state_d = (cnt_q == CNT_WIDTH'(1)) ? S_FINISH : S_RECV;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    addr_d = addr_q;
    asm_d  = asm_q;
    data_d = data_q;
    idx_d  = idx_q;
    err_d  = err_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          if (overflow) begin
            err_d = 1'b1;
          end else begin
            err_d  = 1'b0;
            cnt_d  = WORD_COUNT;
            addr_d = 64'(BASE_ADDR);
            idx_d  = 2'd0;
          end
        end
      end
      S_RECV: begin
        // The fourth byte goes straight into the output word alongside the three held ones.
        if (BYTE_VALID) begin
          idx_d = idx_q + 2'd1;
          case (idx_q)
            2'd0:    asm_d[7:0]   = BYTE_IN;
            2'd1:    asm_d[15:8]  = BYTE_IN;
            2'd2:    asm_d[23:16] = BYTE_IN;
            default: data_d       = {BYTE_IN, asm_q};
          endcase
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q - CNT_WIDTH'(1);
        if (cnt_q != CNT_WIDTH'(1)) addr_d = addr_q + 64'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    BYTE_READY = (state_q == S_RECV);
    MEM_WE     = (state_q == S_WRITE);
    BUSY       = (state_q != S_IDLE);
    DONE       = (state_q == S_FINISH);
    ERROR      = err_q;
    MEM_ADDR   = addr_q;
    MEM_DATA   = data_q;
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

  localparam int BASE = 0;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [15:0] WORD_COUNT;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic        MEM_WE;
  logic [63:0] MEM_ADDR;
  logic [31:0] MEM_DATA;
  logic        BUSY;
  logic        DONE;
  logic        ERROR;

  int          n_chk = 0;
  int          n_pass = 0;
  int          done_n = 0;
  int          acc_total = 0;
  int          acc_in_load = 0;
  bit          we_exp = 1'b0;
  bit          mon_on = 1'b0;
  logic [63:0] wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader #(.DEPTH(501), .BASE_ADDR(BASE), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .WORD_COUNT(WORD_COUNT),
    .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID), .BYTE_READY(BYTE_READY),
    .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Reference: every 4th accepted byte of a load yields one write on the following cycle.
  always @(negedge CLK) begin
    if (mon_on) begin
      check("we_timing", MEM_WE, we_exp);
      if (MEM_WE) begin
        check("ready_in_write", BYTE_READY, 0);
        wr_addr.push_back(MEM_ADDR);
        wr_data.push_back(MEM_DATA);
      end
      if (DONE) done_n++;
      we_exp = 1'b0;
      if (!RST_N) begin
        acc_in_load = 0;
      end else if (BYTE_VALID && BYTE_READY) begin
        acc_total++;
        acc_in_load++;
        if (acc_in_load % 4 == 0) we_exp = 1'b1;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, BYTE_READY, 0);
    check({tag, "_we"}, MEM_WE, 0);
    check({tag, "_busy"}, BUSY, 0);
    check({tag, "_done"}, DONE, 0);
    check({tag, "_error"}, ERROR, 0);
    check({tag, "_addr"}, MEM_ADDR, BASE);
    check({tag, "_data"}, MEM_DATA, 0);
  endtask

  task automatic drive_byte(input logic [7:0] b, input int gapmax);
    int t;
    BYTE_VALID = 1'b0;
    repeat ($urandom_range(gapmax, 0)) step();
    BYTE_VALID = 1'b1;
    BYTE_IN    = b;
    t = 0;
    forever begin
      @(negedge CLK);
      if (BYTE_READY) begin
        step();
        break;
      end
      step();
      t++;
      if (t > 100) begin
        check("ready_timeout", BYTE_READY, 1);
        break;
      end
    end
    BYTE_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge CLK);
      t++;
    end while (BUSY && t < 100);
    if (BUSY) check("idle_timeout", BUSY, 0);
    step();
  endtask

  task automatic run_load(input int n, input int gapmax, input bit poke, input bit t1mode);
    logic [7:0] bq[$];
    logic [7:0] t1[4];
    int d0;
    t1 = '{8'h13, 8'h01, 8'hF0, 8'h00};
    d0 = done_n;
    wr_addr.delete();
    wr_data.delete();
    START = 1'b1;
    WORD_COUNT = 16'(n);
    step();
    START = 1'b0;
    @(negedge CLK);
    check("busy_after_start", BUSY, 1);
    check("error_cleared", ERROR, 0);
    if (n == 0) check("done_empty", DONE, 1);
    step();
    for (int i = 0; i < 4 * n; i++) begin
      bq.push_back(t1mode ? t1[i % 4] : 8'($urandom));
      if (poke && i == 5) begin
        START = 1'b1;
        WORD_COUNT = 16'd9;
      end
      drive_byte(bq[i], gapmax);
      START = 1'b0;
    end
    wait_idle();
    check("n_writes", wr_addr.size(), n);
    for (int w = 0; w < n && w < wr_addr.size(); w++) begin
      check("wr_addr", wr_addr[w], BASE + w);
      check("wr_data", wr_data[w], {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]});
    end
    check("done_pulses", done_n - d0, 1);
  endtask

  initial begin
    int a0;
    RST_N = 1'b0;
    START = 1'b0;
    WORD_COUNT = '0;
    BYTE_IN = '0;
    BYTE_VALID = 1'b0;
    repeat (3) step();
    @(negedge CLK);
    check_reset_vals("reset");
    mon_on = 1'b1;
    RST_N = 1'b1;
    step();

    run_load(1, 0, 1'b0, 1'b1);
    if (wr_data.size() > 0) check("addi_word", wr_data[0], 32'h00F00113);

    run_load(3, 3, 1'b0, 1'b0);

    wr_addr.delete();
    START = 1'b1;
    WORD_COUNT = 16'd502;
    step();
    START = 1'b0;
    @(negedge CLK);
    check("overflow_error", ERROR, 1);
    check("overflow_busy", BUSY, 0);
    check("overflow_ready", BYTE_READY, 0);
    repeat (3) step();
    check("overflow_no_we", wr_addr.size(), 0);
    check("overflow_error_sticky", ERROR, 1);
    run_load(501, 0, 1'b0, 1'b0);
    if (wr_addr.size() > 0) check("last_addr", wr_addr[$], 500);

    a0 = acc_total;
    BYTE_VALID = 1'b1;
    BYTE_IN = 8'hA5;
    run_load(0, 0, 1'b0, 1'b0);
    BYTE_VALID = 1'b0;
    check("empty_no_bytes", acc_total - a0, 0);

    START = 1'b1;
    WORD_COUNT = 16'd2;
    step();
    START = 1'b0;
    drive_byte(8'h11, 0);
    drive_byte(8'h22, 0);
    RST_N = 1'b0;
    step();
    @(negedge CLK);
    check_reset_vals("abort");
    RST_N = 1'b1;
    step();
    run_load(2, 2, 1'b0, 1'b0);

    run_load(3, 2, 1'b1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = int'($urandom_range(5, 1));
      run_load(n, 3, (n >= 2) && ($urandom_range(1, 0) == 1), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
